// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - packs a byte stream MSB-first into 32-bit words and writes them to instruction memory
module instruction_loader #(
    parameter int unsigned NUM_INSTRUCTIONS = 3,
    parameter logic [31:0] BASE_ADDR        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] word_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } stateType;

    localparam logic [15:0] LAST_WORD = 16'(NUM_INSTRUCTIONS - 1);

    stateType    state;
    logic [1:0]  byteCnt;
    logic [23:0] partialWord;

    // mem_addr doubles as the running write address so it is already valid when WRITE is entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            byteCnt     <= 2'd0;
            partialWord <= 24'd0;
            in_ready    <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            word_count  <= 16'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RECV;
                        byteCnt     <= 2'd0;
                        partialWord <= 24'd0;
                        word_count  <= 16'd0;
                        mem_addr    <= BASE_ADDR;
                        in_ready    <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end

                RECV: begin
                    if (in_valid && in_ready) begin
                        partialWord <= {partialWord[15:0], in_data};
                        if (byteCnt == 2'd3) begin
                            byteCnt   <= 2'd0;
                            state     <= WRITE;
                            in_ready  <= 1'b0;
                            mem_we    <= 1'b1;
                            mem_wdata <= {partialWord, in_data};
                        end else begin
                            byteCnt <= byteCnt + 2'd1;
                        end
                    end
                end

                WRITE: begin
                    // address, data and strobe stay frozen until the memory takes the word
                    if (mem_ready) begin
                        mem_we     <= 1'b0;
                        word_count <= word_count + 16'd1;
                        mem_addr   <= mem_addr + 32'd4;
                        if (word_count == LAST_WORD) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state    <= RECV;
                            in_ready <= 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - self-checking bench for instruction_loader
module tb_instruction_loader;

    localparam int NUM = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        mem_ready;
    logic        in_ready, mem_we, busy, done;
    logic [31:0] mem_addr, mem_wdata;
    logic [15:0] word_count;
    logic        in_ready2, mem_we2, busy2, done2;
    logic [31:0] mem_addr2, mem_wdata2;
    logic [15:0] word_count2;

    always #5 clk = ~clk;

    instruction_loader #(.NUM_INSTRUCTIONS(NUM), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .busy(busy), .done(done), .word_count(word_count)
    );

    instruction_loader #(.NUM_INSTRUCTIONS(NUM), .BASE_ADDR(32'h0000_0100)) dut2 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_ready(mem_ready), .busy(busy2), .done(done2), .word_count(word_count2)
    );

    typedef struct {
        int gap;
        int stallWord;
        int stallCycles;
        bit startMid;
        int expDone;
    } vecType;

    int passCnt = 0;
    int totalCnt = 0;
    logic [7:0]  loadBytes [12];
    logic [7:0]  defBytes [12];
    logic [63:0] wrQ [$];
    logic [63:0] wrQ2 [$];
    vecType      vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        totalCnt++;
        if (act === req) passCnt++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    // reference: word i is bytes 4i..4i+3 with the first byte most significant
    function automatic logic [31:0] modelWord(input int i);
        return (32'(loadBytes[4*i]) << 24) | (32'(loadBytes[4*i+1]) << 16) |
               (32'(loadBytes[4*i+2]) << 8) | 32'(loadBytes[4*i+3]);
    endfunction

    task automatic runLoad(input int gap, input int stallWord, input int stallCycles,
                           input bit startMid, input bit randMode, input int expDone);
        int cyc, idx, gapLeft, stallLeft, wordsDone;
        bit accepted;
        wrQ.delete();
        wrQ2.delete();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("startDone", 32'(done), 32'd0);
        check("startCount", 32'(word_count), 32'd0);
        check("startInReady", 32'(in_ready), 32'd1);
        check("startBusy", 32'(busy), 32'd1);
        check("startAddr", mem_addr, 32'h0);
        cyc = 0; idx = 0; gapLeft = 0; stallLeft = stallCycles; wordsDone = 0;
        while (!done && cyc < 3000) begin
            if (randMode) begin
                in_valid  = (idx < 12) && ($urandom_range(9) < 7);
                mem_ready = ($urandom_range(9) < 7);
            end else begin
                in_valid  = (idx < 12) && (gapLeft == 0);
                mem_ready = !(mem_we && wordsDone == stallWord && stallLeft > 0);
            end
            in_data = (idx < 12) ? loadBytes[idx] : 8'h00;
            start   = startMid && (cyc == 2);
            @(negedge clk);
            accepted = in_valid && in_ready;
            if (mem_we && mem_ready) begin
                wrQ.push_back({mem_addr, mem_wdata});
                wordsDone++;
            end
            if (mem_we2 && mem_ready) wrQ2.push_back({mem_addr2, mem_wdata2});
            if (mem_we && !mem_ready) begin
                stallLeft--;
                check("stallAddr", mem_addr, 32'(4 * wordsDone));
                check("stallData", mem_wdata, modelWord(wordsDone));
                check("stallInReady", 32'(in_ready), 32'd0);
            end
            @(posedge clk);
            #1;
            cyc++;
            if (accepted) begin
                idx++;
                gapLeft = gap;
            end else if (!in_valid && gapLeft > 0) begin
                gapLeft--;
            end
        end
        in_valid = 1'b0;
        start = 1'b0;
        check("timeout", 32'(done), 32'd1);
        if (expDone >= 0) check("doneCycle", 32'(cyc + 1), 32'(expDone));
        check("bytesUsed", 32'(idx), 32'd12);
        check("finalCount", 32'(word_count), 32'(NUM));
        check("finalBusy", 32'(busy), 32'd0);
        check("finalCount2", 32'(word_count2), 32'(NUM));
        check("nWrites", 32'(wrQ.size()), 32'(NUM));
        check("nWrites2", 32'(wrQ2.size()), 32'(NUM));
        for (int i = 0; i < NUM; i++) begin
            if (i < wrQ.size()) begin
                check("wrAddr", wrQ[i][63:32], 32'(4 * i));
                check("wrData", wrQ[i][31:0], modelWord(i));
            end
            if (i < wrQ2.size()) begin
                check("wrAddrBase100", wrQ2[i][63:32], 32'h100 + 32'(4 * i));
                check("wrDataBase100", wrQ2[i][31:0], modelWord(i));
            end
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_inReady"}, 32'(in_ready), 32'd0);
        check({tag, "_memWe"}, 32'(mem_we), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_count"}, 32'(word_count), 32'd0);
        check({tag, "_addr"}, mem_addr, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        bit weSeen;
        defBytes = '{8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93,
                     8'h00, 8'h10, 8'h81, 8'h33};
        vecs[0] = '{gap: 0, stallWord: -1, stallCycles: 0, startMid: 1'b0, expDone: 16};
        vecs[1] = '{gap: 2, stallWord: -1, stallCycles: 0, startMid: 1'b0, expDone: 36};
        vecs[2] = '{gap: 0, stallWord: 1,  stallCycles: 3, startMid: 1'b0, expDone: 19};
        vecs[3] = '{gap: 2, stallWord: 1,  stallCycles: 3, startMid: 1'b0, expDone: 38};
        vecs[4] = '{gap: 0, stallWord: -1, stallCycles: 0, startMid: 1'b1, expDone: 16};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 checkAllZero("resetInit");
        @(negedge clk);
        reset = 1'b0;

        loadBytes = defBytes;
        check("defWord0", modelWord(0), 32'h0000_0013);
        for (int v = 0; v < 5; v++)
            runLoad(vecs[v].gap, vecs[v].stallWord, vecs[v].stallCycles,
                    vecs[v].startMid, 1'b0, vecs[v].expDone);

        // asynchronous reset from DONE: outputs clear between clock edges
        @(negedge clk);
        #2 reset = 1'b1;
        #1 checkAllZero("asyncReset");
        @(negedge clk);
        reset = 1'b0;

        // reset after two bytes of the first word
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b0;
        #2 reset = 1'b1;
        #1 checkAllZero("midWordReset");
        weSeen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            weSeen = weSeen | mem_we;
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            weSeen = weSeen | mem_we;
        end
        check("noWriteAfterReset", 32'(weSeen), 32'd0);
        runLoad(0, -1, 0, 1'b0, 1'b0, 16);

        for (int r = 0; r < 6; r++) begin
            for (int b = 0; b < 12; b++) loadBytes[b] = 8'($urandom_range(255));
            runLoad(0, -1, 0, 1'b0, 1'b1, -1);
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
